// File: rtl/ds_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight GPR writes with per-register
// counters and resolves rs/rt operands from prioritised forwarding sources.
module ds_scoreboard #(
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      ds_valid,
    input  logic                      es_allowin,
    input  logic [4:0]                ds_rs,
    input  logic [4:0]                ds_rt,
    input  logic                      ds_rs_used,
    input  logic                      ds_rt_used,
    input  logic                      ds_gr_we,
    input  logic [4:0]                ds_dest,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [NUM_FWD*5-1:0]      fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      retire_valid,
    input  logic [4:0]                retire_addr,
    output logic [DATA_W-1:0]         rs_value,
    output logic [DATA_W-1:0]         rt_value,
    output logic                      ds_stall,
    output logic                      ds_fire,
    output logic                      busy,
    output logic                      underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              unresolved;
    } operand_t;

    // Entry 0 exists only to keep indexing uniform; it is held at zero.
    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic             busy_next;
    logic             underflow_next;

    logic [CNT_W-1:0] pend_rs;
    logic [CNT_W-1:0] pend_rt;
    logic [CNT_W-1:0] pend_dest;
    operand_t         rs_res;
    operand_t         rt_res;
    logic             dest_full;
    logic             do_inc;
    logic             do_dec;

    // The lowest matching source wins outright, even when it is not ready yet.
    function automatic operand_t resolve(input logic [4:0]        addr,
                                         input logic [DATA_W-1:0] rf_data,
                                         input logic [CNT_W-1:0]  pend);
        operand_t res;
        logic     hit;
        res.value      = rf_data;
        res.unresolved = (pend != '0);
        hit            = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && fwd_valid[i] && (fwd_addr[i*5 +: 5] == addr)) begin
                hit            = 1'b1;
                res.value      = fwd_data[i*DATA_W +: DATA_W];
                res.unresolved = !fwd_ready[i];
            end
        end
        if (addr == 5'd0) begin
            res.value      = '0;
            res.unresolved = 1'b0;
        end
        return res;
    endfunction

    // While reset is high the counters are treated as already cleared.
    always_comb begin
        pend_rs   = reset ? '0 : cnt[ds_rs];
        pend_rt   = reset ? '0 : cnt[ds_rt];
        pend_dest = reset ? '0 : cnt[ds_dest];
    end

    always_comb begin
        rs_res = resolve(ds_rs, rf_rdata1, pend_rs);
        rt_res = resolve(ds_rt, rf_rdata2, pend_rt);
    end

    assign rs_value = rs_res.value;
    assign rt_value = rt_res.value;

    // A full counter may still accept a write when the same register retires now.
    assign dest_full = ds_gr_we && (ds_dest != 5'd0) && (pend_dest == CNT_MAX)
                       && !(retire_valid && (retire_addr == ds_dest));

    assign ds_stall = ds_valid && ((ds_rs_used && rs_res.unresolved) ||
                                   (ds_rt_used && rt_res.unresolved) ||
                                   dest_full);
    assign ds_fire  = ds_valid && !ds_stall && es_allowin;

    assign do_inc = ds_fire && ds_gr_we && (ds_dest != 5'd0);
    assign do_dec = retire_valid && (retire_addr != 5'd0);

    // NOTE: every target is assigned a default first so no path can infer a latch;
    // blocking assignments are correct here because this block is purely combinational.
    always_comb begin
        cnt_next       = cnt;
        underflow_next = underflow_err;
        busy_next      = 1'b0;
        for (int r = 1; r < 32; r++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit = do_inc && (ds_dest == 5'(r));
            dec_hit = do_dec && (retire_addr == 5'(r));
            if (dec_hit && (cnt[r] == '0)) begin
                underflow_next = 1'b1;
            end
            if (inc_hit && !dec_hit) begin
                cnt_next[r] = cnt[r] + 1'b1;
            end else if (dec_hit && !inc_hit && (cnt[r] != '0)) begin
                cnt_next[r] = cnt[r] - 1'b1;
            end
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt_next[r] = '0;
            end
        end
        cnt_next[0] = '0;
        for (int r = 1; r < 32; r++) begin
            busy_next = busy_next | (cnt_next[r] != '0);
        end
    end

    // NOTE: the counter array is control state, so every entry is reset explicitly
    // rather than left to power-up values; state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            busy          <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            busy          <= busy_next;
            underflow_err <= underflow_next;
        end
    end

endmodule

// File: tb/tb_ds_scoreboard.sv
// Self-checking bench for ds_scoreboard: vector table for operand resolution plus
// hand-written sequences for counter, flush, underflow and reset behaviour.
module tb_ds_scoreboard;

    localparam int NF = 3;
    localparam int CW = 2;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             ds_valid;
    logic             es_allowin;
    logic [4:0]       ds_rs;
    logic [4:0]       ds_rt;
    logic             ds_rs_used;
    logic             ds_rt_used;
    logic             ds_gr_we;
    logic [4:0]       ds_dest;
    logic [DW-1:0]    rf_rdata1;
    logic [DW-1:0]    rf_rdata2;
    logic [NF-1:0]    fwd_valid;
    logic [NF-1:0]    fwd_ready;
    logic [NF*5-1:0]  fwd_addr;
    logic [NF*DW-1:0] fwd_data;
    logic             retire_valid;
    logic [4:0]       retire_addr;
    logic [DW-1:0]    rs_value;
    logic [DW-1:0]    rt_value;
    logic             ds_stall;
    logic             ds_fire;
    logic             busy;
    logic             underflow_err;

    int errors = 0;
    int checks = 0;

    ds_scoreboard #(.NUM_FWD(NF), .CNT_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ds_valid(ds_valid), .es_allowin(es_allowin),
        .ds_rs(ds_rs), .ds_rt(ds_rt), .ds_rs_used(ds_rs_used), .ds_rt_used(ds_rt_used),
        .ds_gr_we(ds_gr_we), .ds_dest(ds_dest),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retire_valid(retire_valid), .retire_addr(retire_addr),
        .rs_value(rs_value), .rt_value(rt_value),
        .ds_stall(ds_stall), .ds_fire(ds_fire),
        .busy(busy), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic        stall;
        logic        fire;
        logic        rs_chk;
        logic [31:0] rs;
        logic        rt_chk;
        logic [31:0] rt;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rs_used;
        logic        rt_used;
        logic        allowin;
        logic [2:0]  fv;
        logic [2:0]  fr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        stall;
        logic        rs_chk;
        logic [31:0] rs_v;
        logic        rt_chk;
        logic [31:0] rt_v;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic stall, input logic fire,
                              input logic rs_chk, input logic [31:0] rs,
                              input logic rt_chk, input logic [31:0] rt);
        exp_t e;
        e.name   = name;
        e.stall  = stall;
        e.fire   = fire;
        e.rs_chk = rs_chk;
        e.rs     = rs;
        e.rt_chk = rt_chk;
        e.rt     = rt;
        sb.push_back(e);
    endtask

    // Outputs are combinational: compare at the falling edge, before the next commit.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_stall"}, 32'(ds_stall), 32'(e.stall));
            check({e.name, "_fire"}, 32'(ds_fire), 32'(e.fire));
            if (e.rs_chk) check({e.name, "_rs"}, rs_value, e.rs);
            if (e.rt_chk) check({e.name, "_rt"}, rt_value, e.rt);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush        = 1'b0;
        ds_valid     = 1'b0;
        es_allowin   = 1'b1;
        ds_rs        = 5'd0;
        ds_rt        = 5'd0;
        ds_rs_used   = 1'b0;
        ds_rt_used   = 1'b0;
        ds_gr_we     = 1'b0;
        ds_dest      = 5'd0;
        rf_rdata1    = 32'h1111;
        rf_rdata2    = 32'h2222;
        fwd_valid    = '0;
        fwd_ready    = '0;
        fwd_addr     = '0;
        fwd_data     = {32'hC2, 32'hB1, 32'hA0};
        retire_valid = 1'b0;
        retire_addr  = 5'd0;
    endtask

    task automatic issue_write(input logic [4:0] dest);
        ds_valid   = 1'b1;
        ds_gr_we   = 1'b1;
        ds_dest    = dest;
        ds_rs_used = 1'b0;
        ds_rt_used = 1'b0;
    endtask

    task automatic read_rs(input logic [4:0] r);
        ds_valid   = 1'b1;
        ds_rs      = r;
        ds_rs_used = 1'b1;
    endtask

    task automatic do_retire(input logic [4:0] r);
        retire_valid = 1'b1;
        retire_addr  = r;
    endtask

    initial begin
        // Fields: rs rt rs_used rt_used allowin fv fr a0 a1 a2 | stall rs_chk rs rt_chk rt
        vecs[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 5'd0,  5'd0, 5'd0,
                    1'b0, 1'b1, 32'h1111, 1'b1, 32'h2222};
        vecs[1] = '{5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 3'b101, 3'b101, 5'd7,  5'd0, 5'd7,
                    1'b0, 1'b1, 32'hA0,   1'b1, 32'h2222};
        vecs[2] = '{5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 3'b101, 3'b100, 5'd7,  5'd0, 5'd7,
                    1'b1, 1'b0, 32'h0,    1'b1, 32'h2222};
        vecs[3] = '{5'd7, 5'd8, 1'b0, 1'b1, 1'b1, 3'b101, 3'b100, 5'd7,  5'd0, 5'd7,
                    1'b0, 1'b0, 32'h0,    1'b1, 32'h2222};
        vecs[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 3'b111, 3'b000, 5'd0,  5'd0, 5'd0,
                    1'b0, 1'b1, 32'h0,    1'b1, 32'h0};
        vecs[5] = '{5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 3'b010, 3'b010, 5'd0,  5'd6, 5'd0,
                    1'b0, 1'b1, 32'h1111, 1'b1, 32'hB1};
        vecs[6] = '{5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 3'b010, 3'b000, 5'd0,  5'd6, 5'd0,
                    1'b1, 1'b1, 32'h1111, 1'b0, 32'h0};
        vecs[7] = '{5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 3'b101, 3'b101, 5'd10, 5'd0, 5'd9,
                    1'b0, 1'b1, 32'hC2,   1'b1, 32'hC2};
        vecs[8] = '{5'd9, 5'd6, 1'b1, 1'b1, 1'b1, 3'b000, 3'b111, 5'd9,  5'd6, 5'd9,
                    1'b0, 1'b1, 32'h1111, 1'b1, 32'h2222};
        vecs[9] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 5'd0,  5'd0, 5'd0,
                    1'b0, 1'b1, 32'h1111, 1'b1, 32'h2222};

        // Reset: registered outputs clear; stall logic stays live during reset.
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        check("R_busy", 32'(busy), 32'd0);
        check("R_uflow", 32'(underflow_err), 32'd0);
        read_rs(5'd1);
        expect_out("R_in_reset", 1'b0, 1'b1, 1'b1, 32'h1111, 1'b0, 32'h0);
        sample();
        cyc();
        reset = 1'b0;
        idle();

        // Table: forwarding priority and operand resolution with all counters at zero.
        for (int i = 0; i < 10; i++) begin
            cyc();
            idle();
            ds_valid   = 1'b1;
            ds_rs      = vecs[i].rs;
            ds_rt      = vecs[i].rt;
            ds_rs_used = vecs[i].rs_used;
            ds_rt_used = vecs[i].rt_used;
            es_allowin = vecs[i].allowin;
            fwd_valid  = vecs[i].fv;
            fwd_ready  = vecs[i].fr;
            fwd_addr   = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
            expect_out($sformatf("V%0d", i), vecs[i].stall, !vecs[i].stall && vecs[i].allowin,
                       vecs[i].rs_chk, vecs[i].rs_v, vecs[i].rt_chk, vecs[i].rt_v);
            sample();
        end

        // A: pending write to r5, then forwarded once the producer is ready.
        cyc(); idle(); issue_write(5'd5);
        expect_out("A_fire", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc(); idle();
        check("A_busy", 32'(busy), 32'd1);
        read_rs(5'd5);
        expect_out("A_pend", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc();
        fwd_valid = 3'b001; fwd_addr[4:0] = 5'd5; fwd_ready = 3'b000;
        expect_out("A_notready", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc();
        fwd_ready = 3'b001; fwd_data[31:0] = 32'h1234;
        expect_out("A_fwd", 1'b0, 1'b1, 1'b1, 32'h1234, 1'b0, 32'h0);
        sample();
        cyc(); idle(); do_retire(5'd5);
        cyc(); idle();
        check("A_busy_clear", 32'(busy), 32'd0);
        read_rs(5'd5);
        expect_out("A_free", 1'b0, 1'b1, 1'b1, 32'h1111, 1'b0, 32'h0);
        sample();

        // B: saturate r9, a same-cycle retire lets a fourth write through.
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(); issue_write(5'd9);
            expect_out($sformatf("B_fire%0d", k), 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            sample();
        end
        cyc(); idle(); issue_write(5'd9);
        expect_out("B_full", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc(); do_retire(5'd9);
        expect_out("B_full_retire", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc(); retire_valid = 1'b0;
        expect_out("B_still_full", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(); do_retire(5'd9);
        end
        cyc(); idle();
        check("B_drained", 32'(busy), 32'd0);
        check("B_no_uflow", 32'(underflow_err), 32'd0);

        // C: flush overrides a retire and an issue in the same cycle.
        issue_write(5'd4);
        expect_out("C_fire", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc(); idle(); do_retire(5'd4); flush = 1'b1; issue_write(5'd10);
        expect_out("C_flush_fire", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc(); idle();
        check("C_busy", 32'(busy), 32'd0);
        check("C_uflow", 32'(underflow_err), 32'd0);
        read_rs(5'd4); ds_rt = 5'd10; ds_rt_used = 1'b1;
        expect_out("C_cleared", 1'b0, 1'b1, 1'b1, 32'h1111, 1'b1, 32'h2222);
        sample();

        // D: sticky underflow survives flush; reset clears it and drops pending state.
        cyc(); idle(); do_retire(5'd3);
        cyc(); idle();
        check("D_uflow_set", 32'(underflow_err), 32'd1);
        flush = 1'b1;
        cyc(); idle();
        check("D_uflow_kept", 32'(underflow_err), 32'd1);
        issue_write(5'd12);
        expect_out("D_fire", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        sample();
        cyc(); idle();
        check("D_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        read_rs(5'd12);
        expect_out("D_reset_stall", 1'b0, 1'b1, 1'b1, 32'h1111, 1'b0, 32'h0);
        sample();
        cyc(); reset = 1'b0; idle();
        check("D_reset_uflow", 32'(underflow_err), 32'd0);
        check("D_reset_busy", 32'(busy), 32'd0);
        read_rs(5'd12);
        expect_out("D_after_reset", 1'b0, 1'b1, 1'b1, 32'h1111, 1'b0, 32'h0);
        sample();

        // E: register 0 is never tracked and always reads as zero.
        cyc(); idle();
        ds_valid = 1'b1; ds_rs_used = 1'b1; ds_rt_used = 1'b1;
        ds_gr_we = 1'b1; ds_dest = 5'd0;
        fwd_valid = 3'b111; fwd_ready = 3'b000;
        expect_out("E_zero", 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
        sample();
        cyc(); idle();
        check("E_no_track", 32'(busy), 32'd0);

        if (sb.size() != 0) begin
            check("SB_empty", 32'(sb.size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ds_scoreboard.md
DS_SCOREBOARD -- requirements
Module: ds_scoreboard

Interface
REQ-001 Parameter NUM_FWD, default 3, number of forwarding sources; index 0 has highest priority (youngest stage).
REQ-002 Parameter CNT_W, default 2, width of the per-register pending-write counter.
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 Clocking: one clock; reset is synchronous and active-high, ports clk and reset.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 flush  in  1  discard all in-flight writes.
REQ-008 ds_valid  in  1  decode stage holds a valid instruction.
REQ-009 es_allowin  in  1  execute stage accepts this cycle.
REQ-010 ds_rs, ds_rt  in  5 each  source register numbers.
REQ-011 ds_rs_used, ds_rt_used  in  1 each  the source is actually read.
REQ-012 ds_gr_we, ds_dest  in  1, 5  instruction writes GPR ds_dest.
REQ-013 rf_rdata1, rf_rdata2  in  DATA_W each  regfile read data for rs and rt.
REQ-014 fwd_valid, fwd_ready  in  NUM_FWD each  per-source destination valid / data already produced.
REQ-015 fwd_addr, fwd_data  in  NUM_FWD*5, NUM_FWD*DATA_W  per-source destination and result, source i at slice i.
REQ-016 retire_valid, retire_addr  in  1, 5  writeback commits a GPR write.
REQ-017 rs_value, rt_value  out  DATA_W each  resolved operands.
REQ-018 ds_stall  out  1  decode must hold.
REQ-019 ds_fire  out  1  ds_valid && !ds_stall && es_allowin.
REQ-020 busy  out  1  registered; any counter non-zero.
REQ-021 underflow_err  out  1  sticky; retire seen while the counter was zero.

Function
REQ-022 Each register r=1..31 SHALL have a counter cnt[r] of CNT_W bits; register 0 SHALL never be tracked and SHALL always resolve to value 0 with no stall.
REQ-023 When ds_fire is high, ds_gr_we is high and ds_dest is not 0, cnt[ds_dest] SHALL increment at the next edge.
REQ-024 When retire_valid is high and retire_addr is not 0, cnt[retire_addr] SHALL decrement at the next edge.
REQ-025 When an increment and a decrement hit the same register in one cycle, that counter SHALL stay unchanged.
REQ-026 When a retire hits a zero counter, the counter SHALL stay 0 and underflow_err SHALL set at the next edge.
REQ-027 Operand resolution for rs (rt identical with rf_rdata2): source i matches when fwd_valid[i] is high and fwd_addr[i] equals ds_rs.
REQ-028 The lowest matching index SHALL be selected; if it is ready, rs_value SHALL be its fwd_data.
REQ-029 If the selected source is not ready, the operand SHALL be unresolved; lower-priority matches SHALL not be consulted.
REQ-030 With no match, rs_value SHALL be rf_rdata1; if cnt[ds_rs] is non-zero in that case, the operand SHALL be unresolved.
REQ-031 ds_stall SHALL be high when ds_valid is high and either (a) a used operand is unresolved, or (b) ds_gr_we is high, ds_dest is not 0, cnt[ds_dest] equals all-ones, and no same-cycle retire to ds_dest occurs.
REQ-032 ds_stall, ds_fire and the operand values SHALL be combinational, with no cycle of latency.
REQ-033 Unused operands (_used low) SHALL never cause a stall.
REQ-034 flush SHALL clear every counter at the next edge and SHALL override any same-cycle increment or decrement.
REQ-035 flush SHALL not clear underflow_err.
REQ-036 busy SHALL reflect the OR of the counters after each edge, and SHALL be 0 in the cycle after a flush.

Reset
REQ-037 On reset, all counters SHALL be 0, busy SHALL be 0, underflow_err SHALL be 0, and reset SHALL override flush, issue and retire.
REQ-038 While reset is high, ds_stall SHALL follow REQ-031 with all counters at 0.
REQ-039 Reset asserted mid-operation SHALL drop all pending state with no retire required.

Verification
REQ-040 Fire addu with dest 5, then ds_rs=5 with fwd_valid[0]=1, fwd_addr[0]=5, fwd_ready[0]=0 -> ds_stall=1; next cycle fwd_ready[0]=1, fwd_data[0]=0x1234 -> rs_value=0x1234, ds_stall=0.
REQ-041 Sources 0 and 2 both match r7 with data 0xA and 0xB, both ready -> rs_value=0xA; make source 0 not ready -> stall, even though source 2 is ready.
REQ-042 CNT_W=2: fire three writes to r9 with no retire -> cnt=3; a fourth write to r9 stalls; the same cycle plus retire r9 -> fires, cnt stays 3.
REQ-043 cnt[r4]=1 with retire r4 and a flush in the same cycle -> next cycle all counters 0, busy=0, underflow_err=0.
REQ-044 Retire r3 with cnt=0 -> underflow_err=1 and remains 1 through a flush; reset -> 0.
REQ-045 ds_rs=0, ds_rt=0, ds_gr_we with dest 0 -> rs_value=rt_value=0, no stall, and no counter change after ds_fire.
